// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run/timeout controller and its watchdog.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } run_state_e;

  typedef enum logic [1:0] {
    STATUS_NONE    = 2'b00,
    STATUS_OK      = 2'b01,
    STATUS_TIMEOUT = 2'b10
  } run_status_e;

  localparam logic [31:0] RUN_TIMEOUT_DEFAULT = 32'h7735_9400;
  localparam logic [31:0] RUN_CYCLES_MAX      = 32'hFFFF_FFFF;

endpackage

// File: rtl/run_timeout_ctrl_wdt.sv
// Watchdog down-counter: load/reload to LOAD_VALUE, count down while enabled,
// clear to zero whenever neither loading nor enabled; expires at a count of 1.
module wdt_down_cnt
  import run_ctrl_pkg::*;
#(
  parameter logic [31:0] LOAD_VALUE = RUN_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic reload_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (load_i) begin
      cnt_d = LOAD_VALUE;
    end else if (enable_i) begin
      if (reload_i) begin
        cnt_d = LOAD_VALUE;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 32'd1);

endmodule

// File: rtl/run_timeout_ctrl.sv
// Host-facing run controller with watchdog timeout and datapath flush.
// Define RUN_CYCLE_CNT_EN to add the run_cycles elapsed-cycle counter port.
module run_timeout_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = RUN_TIMEOUT_DEFAULT,
  parameter int unsigned FLUSH_CYCLES   = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        ap_start,
  output logic        ap_ready,
  output logic        ap_idle,
  output logic        ap_done,
  output logic        dp_start,
  input  logic        dp_done,
  input  logic        dp_progress,
  output logic        dp_abort,
  output logic        timeout_pulse,
  output logic [1:0]  status
`ifdef RUN_CYCLE_CNT_EN
  ,
  output logic [31:0] run_cycles
`endif
);

  run_state_e  state_q, state_d;
  run_status_e status_q, status_d;
  logic [31:0] flush_q, flush_d;
  logic        wdt_load, wdt_enable, wdt_expire;
  logic        timeout_c;

  wdt_down_cnt #(
    .LOAD_VALUE(TIMEOUT_CYCLES)
  ) u_wdt (
    .clk_i   (aclk),
    .rst_i   (areset),
    .load_i  (wdt_load),
    .reload_i(dp_progress),
    .enable_i(wdt_enable),
    .expire_o(wdt_expire)
  );

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    flush_d   = '0;
    wdt_load  = 1'b0;
    timeout_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ap_start) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        wdt_load = 1'b1;
        status_d = STATUS_NONE;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        // Completion wins over expiry; a heartbeat in the expiry cycle cancels it.
        if (dp_done) begin
          state_d  = ST_DONE;
          status_d = STATUS_OK;
        end else if (wdt_expire && !dp_progress) begin
          timeout_c = 1'b1;
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_q == 32'(FLUSH_CYCLES - 1)) begin
          state_d  = ST_DONE;
          status_d = STATUS_TIMEOUT;
        end else begin
          flush_d = flush_q + 32'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Watchdog only runs while staying in RUN, so it reads zero once RUN is left.
  assign wdt_enable = (state_q == ST_RUN) && (state_d == ST_RUN);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      status_q <= STATUS_NONE;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      flush_q  <= flush_d;
    end
  end

  assign ap_idle       = areset || (state_q == ST_IDLE);
  assign ap_ready      = !areset && (state_q == ST_LAUNCH);
  assign dp_start      = !areset && (state_q == ST_LAUNCH);
  assign ap_done       = !areset && (state_q == ST_DONE);
  assign dp_abort      = !areset && (state_q == ST_FLUSH);
  assign timeout_pulse = !areset && timeout_c;
  assign status        = areset ? STATUS_NONE : status_q;

`ifdef RUN_CYCLE_CNT_EN
  logic [31:0] run_cycles_q, run_cycles_d;

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (state_q == ST_LAUNCH) begin
      run_cycles_d = 32'd1;
    end else if (((state_q == ST_RUN) || (state_q == ST_FLUSH)) &&
                 (run_cycles_q != RUN_CYCLES_MAX)) begin
      run_cycles_d = run_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      run_cycles_q <= '0;
    end else begin
      run_cycles_q <= run_cycles_d;
    end
  end

  assign run_cycles = areset ? '0 : run_cycles_q;
`endif

endmodule

// File: tb/tb_run_timeout_ctrl.sv
// Scoreboard bench for run_timeout_ctrl (TIMEOUT_CYCLES=8, FLUSH_CYCLES=4).
`timescale 1ns/1ps
module tb_run_timeout_ctrl;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic ap_start = 1'b0;
  logic dp_done = 1'b0;
  logic dp_progress = 1'b0;
  logic ap_ready, ap_idle, ap_done, dp_start, dp_abort, timeout_pulse;
  logic [1:0] status;
`ifdef RUN_CYCLE_CNT_EN
  logic [31:0] run_cycles;
`endif

  run_timeout_ctrl #(
    .TIMEOUT_CYCLES(32'd8),
    .FLUSH_CYCLES  (4)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_idle      (ap_idle),
    .ap_done      (ap_done),
    .dp_start     (dp_start),
    .dp_done      (dp_done),
    .dp_progress  (dp_progress),
    .dp_abort     (dp_abort),
    .timeout_pulse(timeout_pulse),
    .status       (status)
`ifdef RUN_CYCLE_CNT_EN
    ,
    .run_cycles   (run_cycles)
`endif
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef enum int {EV_READY = 0, EV_TIMEOUT = 1, EV_DONE = 2} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       cyc;
    int       status;
    int       aborts;
    int       abort_first;
    int       rcyc;
  } ev_t;

  ev_t exp_q[$];
  int  base = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_e k, input int off, input int st, input int ab,
                      input int abf, input int rc);
    ev_t e;
    e.kind        = k;
    e.cyc         = base + off;
    e.status      = st;
    e.aborts      = ab;
    e.abort_first = (abf < 0) ? -1 : base + abf;
    e.rcyc        = rc;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per observed output pulse.
  int ab_cnt = 0;
  int ab_first = -1;

  task automatic observe(input ev_kind_e k);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", longint'(k), -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", longint'(k), longint'(e.kind));
    chk("event_cycle", cyc, e.cyc);
    case (k)
      EV_READY: begin
        chk("dp_start_and_ap_ready", {ap_ready, dp_start}, 3);
        ab_cnt   = 0;
        ab_first = -1;
      end
      EV_DONE: begin
        chk("done_status", status, e.status);
        chk("abort_cycle_count", ab_cnt, e.aborts);
        chk("abort_first_cycle", ab_first, e.abort_first);
`ifdef RUN_CYCLE_CNT_EN
        chk("run_cycles_at_done", run_cycles, e.rcyc);
`endif
      end
      default: ;
    endcase
  endtask

  always @(negedge aclk) begin
    if (areset) begin
      ab_cnt   = 0;
      ab_first = -1;
    end else begin
      if (dp_abort) begin
        if (ab_cnt == 0) ab_first = cyc;
        ab_cnt++;
      end
      if (ap_ready || dp_start) observe(EV_READY);
      if (timeout_pulse)        observe(EV_TIMEOUT);
      if (ap_done)              observe(EV_DONE);
    end
  end

  // Bit i of each mask drives that input during cycle base+i.
  task automatic run_vec(input logic [31:0] st_m, input logic [31:0] dn_m,
                         input logic [31:0] pg_m, input logic [31:0] rs_m, input int len);
    for (int i = 0; i < len; i++) begin
      ap_start    = st_m[i];
      dp_done     = dn_m[i];
      dp_progress = pg_m[i];
      areset      = rs_m[i];
      @(posedge aclk); #1;
    end
    ap_start    = 1'b0;
    dp_done     = 1'b0;
    dp_progress = 1'b0;
    areset      = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while (!ap_idle && n < 40) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("idle_within_budget", ap_idle, 1);
    repeat (2) begin
      @(posedge aclk); #1;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ap_idle"}, ap_idle, 1);
    chk({tag, "_dp_abort"}, dp_abort, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_ap_ready"}, ap_ready, 0);
    chk({tag, "_ap_done"}, ap_done, 0);
    chk({tag, "_timeout_pulse"}, timeout_pulse, 0);
`ifdef RUN_CYCLE_CNT_EN
    chk({tag, "_run_cycles"}, run_cycles, 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    #1;
    chk_reset_state("reset");

    // Normal run: done at 5
    base = cyc;
    push(EV_READY, 1, 0, 0, -1, 0);
    push(EV_DONE, 6, 1, 0, -1, 5);
    run_vec(32'h1, 32'h20, 32'h0, 32'h0, 7);
    settle();

    // Timeout with no progress
    base = cyc;
    push(EV_READY, 1, 0, 0, -1, 0);
    push(EV_TIMEOUT, 9, 0, 0, -1, 0);
    push(EV_DONE, 14, 2, 4, 10, 13);
    run_vec(32'h1, 32'h0, 32'h0, 32'h0, 2);
    settle();

    // Heartbeats at 6 and 12
    base = cyc;
    push(EV_READY, 1, 0, 0, -1, 0);
    push(EV_TIMEOUT, 20, 0, 0, -1, 0);
    push(EV_DONE, 25, 2, 4, 21, 24);
    run_vec(32'h1, 32'h0, 32'h1040, 32'h0, 13);
    settle();

    // dp_done in expiry cycle
    base = cyc;
    push(EV_READY, 1, 0, 0, -1, 0);
    push(EV_DONE, 10, 1, 0, -1, 9);
    run_vec(32'h1, 32'h200, 32'h0, 32'h0, 10);
    settle();

    // dp_progress in expiry cycle, done later
    base = cyc;
    push(EV_READY, 1, 0, 0, -1, 0);
    push(EV_DONE, 13, 1, 0, -1, 12);
    run_vec(32'h1, 32'h1000, 32'h200, 32'h0, 13);
    settle();

    // Reset at cycle 11 (mid-flush), then relaunch on first cycle after release
    base = cyc;
    push(EV_READY, 1, 0, 0, -1, 0);
    push(EV_TIMEOUT, 9, 0, 0, -1, 0);
    run_vec(32'h1, 32'h0, 32'h0, 32'h800, 12);
    #1;
    chk_reset_state("midflush_reset");
    base = cyc;
    push(EV_READY, 1, 0, 0, -1, 0);
    push(EV_DONE, 4, 1, 0, -1, 3);
    run_vec(32'h1, 32'h8, 32'h0, 32'h0, 5);
    settle();

    // ap_start held through two runs
    base = cyc;
    push(EV_READY, 1, 0, 0, -1, 0);
    push(EV_DONE, 5, 1, 0, -1, 4);
    push(EV_READY, 7, 0, 0, -1, 0);
    push(EV_DONE, 11, 1, 0, -1, 4);
    run_vec(32'h7FF, 32'h410, 32'h0, 32'h0, 12);
    settle();

    chk("expected_events_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/run_timeout_ctrl.md
RUN_TIMEOUT_CTRL -- requirements
Module: run_timeout_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'h7735_9400 (about 8 s at 250 MHz): watchdog reload value; SHALL be >= 2.
REQ-002 Parameter FLUSH_CYCLES, default 16: abort hold length in cycles; SHALL be >= 1.
REQ-003 Port aclk, input, 1: sole clock; all logic SHALL be on its rising edge.
REQ-004 Port areset, input, 1: synchronous, active-high reset.
REQ-005 Port ap_start, input, 1: level run request from host control.
REQ-006 Port ap_ready, output, 1: one-cycle pulse when a run is accepted.
REQ-007 Port ap_idle, output, 1: high while in IDLE.
REQ-008 Port ap_done, output, 1: one-cycle pulse at run end.
REQ-009 Port dp_start, output, 1: one-cycle launch pulse to the merger datapath.
REQ-010 Port dp_done, input, 1: datapath completion pulse.
REQ-011 Port dp_progress, input, 1: datapath heartbeat; reloads the watchdog.
REQ-012 Port dp_abort, output, 1: level flush/abort command to the datapath.
REQ-013 Port timeout_pulse, output, 1: one-cycle pulse on watchdog expiry.
REQ-014 Port status, output, 2: 2'b00 none, 2'b01 ok, 2'b10 timeout; held until the next launch.
REQ-015 Port run_cycles, output, 32: elapsed cycles of the last or current run; present only under REQ-033.

Function
REQ-016 FSM states SHALL be IDLE, LAUNCH, RUN, FLUSH, DONE.
REQ-017 IDLE with ap_start=1 SHALL go to LAUNCH next cycle; dp_done and dp_progress are ignored in IDLE.
REQ-018 LAUNCH SHALL last exactly 1 cycle:
- assert dp_start and ap_ready
- load the watchdog with TIMEOUT_CYCLES
- set status to 2'b00
- go to RUN.
REQ-019 The watchdog SHALL behave as follows in RUN:
- decrement by 1 per cycle
- a cycle with dp_progress=1 reloads it to TIMEOUT_CYCLES instead
- it expires when the count reaches 1, which is TIMEOUT_CYCLES cycles after the last load cycle.
REQ-020 RUN with dp_done=1 SHALL go to DONE with status 2'b01, whatever the watchdog state.
REQ-021 A RUN expiry with dp_done=0 SHALL:
- pulse timeout_pulse for 1 cycle
- go to FLUSH.
REQ-022 Simultaneous expiry and dp_progress SHALL reload the watchdog and not time out; simultaneous dp_done and expiry SHALL complete with ok and not pulse timeout_pulse.
REQ-023 FLUSH SHALL hold dp_abort=1 for exactly FLUSH_CYCLES cycles, ignore dp_done and dp_progress, then go to DONE with status 2'b10.
REQ-024 DONE SHALL last 1 cycle: pulse ap_done, go to IDLE.
REQ-025 Latency: ap_start in IDLE at cycle t gives dp_start at t+1; dp_done at cycle t in RUN gives ap_done at t+1.
REQ-026 ap_start held high SHALL produce back-to-back runs with exactly one IDLE cycle between ap_done and the next ap_ready.
REQ-027 The watchdog SHALL be inactive (zero) outside LAUNCH and RUN; timeout_pulse never asserts outside RUN.

Reset
REQ-028 areset=1 SHALL force the following regardless of state, including mid-RUN or mid-FLUSH:
- state IDLE and watchdog 0
- ap_idle=1 and status=2'b00
- run_cycles=0
- all pulse outputs and dp_abort low.
REQ-029 The first cycle after reset release SHALL sample ap_start normally.
REQ-030 Reset SHALL NOT generate dp_abort; the datapath shares areset.

Configuration
REQ-031 Macro RUN_CYCLE_CNT_EN SHALL select the cycle-counter feature.
REQ-032 Without RUN_CYCLE_CNT_EN, the run_cycles port and its counter are absent; all other behaviour is unchanged.
REQ-033 With RUN_CYCLE_CNT_EN, run_cycles SHALL:
- be set to 1 in LAUNCH
- increment once per RUN and FLUSH cycle, saturating at 32'hFFFF_FFFF
- hold from DONE until the next LAUNCH.

Structure
REQ-034 Shared package run_ctrl_pkg SHALL hold:
- the state enum
- the status codes 2'b00, 2'b01, 2'b10
- the default timeout constant 32'h7735_9400.
REQ-035 The watchdog SHALL be one sub-module, wdt_down_cnt, with load, reload, enable and expire ports; the FSM, flush counter and cycle counter stay in run_timeout_ctrl.

Verification
All scenarios use TIMEOUT_CYCLES=8 and FLUSH_CYCLES=4.
REQ-036 Normal run: ap_start at cycle 0, dp_done at cycle 5 -> dp_start and ap_ready at cycle 1, ap_done at cycle 6, status 2'b01, run_cycles=5, no timeout_pulse.
REQ-037 Timeout: ap_start at cycle 0, no progress, no done -> timeout_pulse at cycle 9, dp_abort high for cycles 10-13, ap_done at cycle 14, status 2'b10.
REQ-038 Heartbeat: dp_progress at cycles 6 and 12, then silence -> timeout_pulse at cycle 20, not earlier.
REQ-039 Collision: dp_done in the expiry cycle -> status 2'b01, timeout_pulse never asserted, dp_abort never asserted.
REQ-040 Reset mid-FLUSH: areset at cycle 11 of REQ-037 -> the next cycle shows ap_idle=1, dp_abort=0, status 2'b00; a new ap_start launches normally.
REQ-041 Level ap_start held through 2 runs -> ap_ready pulses exactly twice, with one ap_idle cycle between them.
